// File: rtl/rvfi_csr_shadow_monitor_pkg.sv
// Shared types and constants for the RVFI CSR shadow monitor.
package rvfi_csr_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_e;

endpackage

// File: rtl/rvfi_csr_shadow_monitor_if.sv
// RVFI retirement bus subset carrying one CSR's read/write view.
interface rvfi_csr_shadow_monitor_if #(
  parameter int XLEN = 32,
  parameter int NRET = 1
);
  logic [NRET-1:0]      rvfi_valid;
  logic [NRET*64-1:0]   rvfi_order;
  logic [NRET*XLEN-1:0] rvfi_csr_rmask;
  logic [NRET*XLEN-1:0] rvfi_csr_rdata;
  logic [NRET*XLEN-1:0] rvfi_csr_wmask;
  logic [NRET*XLEN-1:0] rvfi_csr_wdata;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_csr_rmask, rvfi_csr_rdata, rvfi_csr_wmask, rvfi_csr_wdata
  );
  modport slave (
    input rvfi_valid, rvfi_order, rvfi_csr_rmask, rvfi_csr_rdata, rvfi_csr_wmask, rvfi_csr_wdata
  );
endinterface

// File: rtl/rvfi_csr_shadow_monitor_lane.sv
// One retirement channel step: checks read data against the shadow, then folds
// the read and write into it and advances the expected order.
module rvfi_csr_shadow_lane #(
  parameter int               XLEN          = 32,
  parameter logic [XLEN-1:0]  VOLATILE_MASK = '0
) (
  input  logic            valid,
  input  logic [63:0]     order_in,
  input  logic [XLEN-1:0] rmask,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wmask,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] shadow_in,
  input  logic [XLEN-1:0] known_in,
  input  logic            seeded_in,
  input  logic [63:0]     exp_in,
  output logic [XLEN-1:0] shadow_out,
  output logic [XLEN-1:0] known_out,
  output logic            seeded_out,
  output logic [63:0]     exp_out,
  output logic [XLEN-1:0] bad,
  output logic            order_bad
);
  logic [XLEN-1:0] after_read;

  always_comb begin
    shadow_out = shadow_in;
    known_out  = known_in;
    seeded_out = seeded_in;
    exp_out    = exp_in;
    bad        = '0;
    order_bad  = 1'b0;
    after_read = (shadow_in & ~rmask) | (rdata & rmask);
    if (valid) begin
      bad        = (rdata ^ shadow_in) & rmask & known_in;
      shadow_out = (after_read & ~wmask) | (wdata & wmask);
      known_out  = (known_in | rmask | wmask) & ~VOLATILE_MASK;
      // An unseeded tracker accepts any order; afterwards always resync to the observed one.
      order_bad  = seeded_in && (order_in != exp_in);
      exp_out    = order_in + 64'd1;
      seeded_out = 1'b1;
    end
  end
endmodule

// File: rtl/rvfi_csr_shadow_monitor.sv
// Sequential CSR shadow monitor: tracks one CSR across retirements and flags
// read-data contradictions and rvfi_order gaps, with first-error capture.
module rvfi_csr_shadow_monitor
  import rvfi_csr_pkg::*;
#(
  parameter int               XLEN          = XLEN_DEFAULT,
  parameter int               NRET          = 1,
  parameter logic [XLEN-1:0]  VOLATILE_MASK = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  rvfi_csr_shadow_monitor_if.slave    rvfi,
  output logic [XLEN-1:0]             shadow_value,
  output logic [XLEN-1:0]             shadow_known,
  output logic                        mismatch,
  output logic                        order_error,
  output logic                        err_sticky,
  output logic [63:0]                 err_order,
  output logic [XLEN-1:0]             err_bits,
  output logic [31:0]                 retire_count
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] shadow_q, shadow_d, known_q, known_d;
  logic [63:0]     exp_order_q, exp_order_d;
  logic            mismatch_q, mismatch_d, order_error_q, order_error_d;
  logic            err_sticky_q, err_sticky_d;
  logic [63:0]     err_order_q, err_order_d;
  logic [XLEN-1:0] err_bits_q, err_bits_d;
  logic [31:0]     retire_count_q, retire_count_d;

  logic [XLEN-1:0] shadow_c [NRET+1];
  logic [XLEN-1:0] known_c  [NRET+1];
  logic [63:0]     exp_c    [NRET+1];
  logic            seeded_c [NRET+1];
  logic [XLEN-1:0] bad_c    [NRET];
  logic            obad_c   [NRET];

  assign shadow_c[0] = shadow_q;
  assign known_c[0]  = known_q;
  assign exp_c[0]    = exp_order_q;
  assign seeded_c[0] = (state_q != IDLE);

  // Channel k sees the shadow already updated by channels 0..k-1.
  for (genvar k = 0; k < NRET; k++) begin : g_lane
    rvfi_csr_shadow_lane #(.XLEN(XLEN), .VOLATILE_MASK(VOLATILE_MASK)) u_lane (
      .valid     (rvfi.rvfi_valid[k]),
      .order_in  (rvfi.rvfi_order[k*64 +: 64]),
      .rmask     (rvfi.rvfi_csr_rmask[k*XLEN +: XLEN]),
      .rdata     (rvfi.rvfi_csr_rdata[k*XLEN +: XLEN]),
      .wmask     (rvfi.rvfi_csr_wmask[k*XLEN +: XLEN]),
      .wdata     (rvfi.rvfi_csr_wdata[k*XLEN +: XLEN]),
      .shadow_in (shadow_c[k]),
      .known_in  (known_c[k]),
      .seeded_in (seeded_c[k]),
      .exp_in    (exp_c[k]),
      .shadow_out(shadow_c[k+1]),
      .known_out (known_c[k+1]),
      .seeded_out(seeded_c[k+1]),
      .exp_out   (exp_c[k+1]),
      .bad       (bad_c[k]),
      .order_bad (obad_c[k])
    );
  end

  logic            found;
  logic [63:0]     cap_order;
  logic [XLEN-1:0] cap_bits;

  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_c[NRET];
    known_d        = known_c[NRET];
    exp_order_d    = exp_c[NRET];
    mismatch_d     = 1'b0;
    order_error_d  = 1'b0;
    err_sticky_d   = err_sticky_q;
    err_order_d    = err_order_q;
    err_bits_d     = err_bits_q;
    retire_count_d = retire_count_q;
    found          = 1'b0;
    cap_order      = '0;
    cap_bits       = '0;
    for (int k = 0; k < NRET; k++) begin
      retire_count_d = retire_count_d + 32'(rvfi.rvfi_valid[k]);
      mismatch_d     = mismatch_d | (|bad_c[k]);
      order_error_d  = order_error_d | obad_c[k];
      if (!found && ((|bad_c[k]) || obad_c[k])) begin
        found     = 1'b1;
        cap_order = rvfi.rvfi_order[k*64 +: 64];
        cap_bits  = bad_c[k];
      end
    end
    // Only the first error is captured; ERROR is left solely through reset.
    if (found && state_q != ERROR) begin
      state_d      = ERROR;
      err_sticky_d = 1'b1;
      err_order_d  = cap_order;
      err_bits_d   = cap_bits;
    end else if (state_q == IDLE && seeded_c[NRET]) begin
      state_d = TRACK;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      shadow_q       <= '0;
      known_q        <= '0;
      exp_order_q    <= '0;
      mismatch_q     <= 1'b0;
      order_error_q  <= 1'b0;
      err_sticky_q   <= 1'b0;
      err_order_q    <= '0;
      err_bits_q     <= '0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      known_q        <= known_d;
      exp_order_q    <= exp_order_d;
      mismatch_q     <= mismatch_d;
      order_error_q  <= order_error_d;
      err_sticky_q   <= err_sticky_d;
      err_order_q    <= err_order_d;
      err_bits_q     <= err_bits_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign shadow_value = shadow_q;
  assign shadow_known = known_q;
  assign mismatch     = mismatch_q;
  assign order_error  = order_error_q;
  assign err_sticky   = err_sticky_q;
  assign err_order    = err_order_q;
  assign err_bits     = err_bits_q;
  assign retire_count = retire_count_q;
endmodule

// File: tb/tb_rvfi_csr_shadow_monitor.sv
// Directed bench: a two-channel monitor and a single-channel volatile (mcycle-style) monitor.
module tb_rvfi_csr_shadow_monitor;
  import rvfi_csr_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  rvfi_csr_shadow_monitor_if #(.XLEN(32), .NRET(2)) bus2 ();
  rvfi_csr_shadow_monitor_if #(.XLEN(32), .NRET(1)) bus1 ();

  logic [31:0] a_shadow, a_known, a_bits, a_cnt;
  logic        a_mis, a_oe, a_sticky;
  logic [63:0] a_order;
  logic [31:0] v_shadow, v_known, v_bits, v_cnt;
  logic        v_mis, v_oe, v_sticky;
  logic [63:0] v_order;

  rvfi_csr_shadow_monitor #(.XLEN(32), .NRET(2), .VOLATILE_MASK(32'h0)) dut (
    .clock(clock), .reset(reset), .rvfi(bus2.slave),
    .shadow_value(a_shadow), .shadow_known(a_known), .mismatch(a_mis), .order_error(a_oe),
    .err_sticky(a_sticky), .err_order(a_order), .err_bits(a_bits), .retire_count(a_cnt)
  );

  rvfi_csr_shadow_monitor #(.XLEN(32), .NRET(1), .VOLATILE_MASK(32'hFFFF_FFFF)) dut_v (
    .clock(clock), .reset(reset), .rvfi(bus1.slave),
    .shadow_value(v_shadow), .shadow_known(v_known), .mismatch(v_mis), .order_error(v_oe),
    .err_sticky(v_sticky), .err_order(v_order), .err_bits(v_bits), .retire_count(v_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus2.rvfi_valid = '0; bus2.rvfi_order = '0;
    bus2.rvfi_csr_rmask = '0; bus2.rvfi_csr_rdata = '0;
    bus2.rvfi_csr_wmask = '0; bus2.rvfi_csr_wdata = '0;
    bus1.rvfi_valid = '0; bus1.rvfi_order = '0;
    bus1.rvfi_csr_rmask = '0; bus1.rvfi_csr_rdata = '0;
    bus1.rvfi_csr_wmask = '0; bus1.rvfi_csr_wdata = '0;
  endtask

  task automatic ret2(input int ch, input logic [63:0] ord, input logic [31:0] rm, input logic [31:0] rd,
                      input logic [31:0] wm, input logic [31:0] wd);
    bus2.rvfi_valid[ch] = 1'b1;
    bus2.rvfi_order[ch*64 +: 64] = ord;
    bus2.rvfi_csr_rmask[ch*32 +: 32] = rm;
    bus2.rvfi_csr_rdata[ch*32 +: 32] = rd;
    bus2.rvfi_csr_wmask[ch*32 +: 32] = wm;
    bus2.rvfi_csr_wdata[ch*32 +: 32] = wd;
  endtask

  task automatic ret1(input logic [63:0] ord, input logic [31:0] rm, input logic [31:0] rd,
                      input logic [31:0] wm, input logic [31:0] wd);
    bus1.rvfi_valid = 1'b1; bus1.rvfi_order = ord;
    bus1.rvfi_csr_rmask = rm; bus1.rvfi_csr_rdata = rd;
    bus1.rvfi_csr_wmask = wm; bus1.rvfi_csr_wdata = wd;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle_bus();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    idle_bus();
    step();
    do_reset();

    // 1: idle after reset
    repeat (5) step();
    check("rst_shadow", a_shadow, 0);
    check("rst_known", a_known, 0);
    check("rst_mis", a_mis, 0);
    check("rst_oe", a_oe, 0);
    check("rst_sticky", a_sticky, 0);
    check("rst_err_order", a_order, 0);
    check("rst_err_bits", a_bits, 0);
    check("rst_count", a_cnt, 0);
    check("rst_state", 64'(dut.state_q), 64'(IDLE));

    // 2: write then consistent read
    ret2(0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0000_00A5);
    step();
    check("wr_shadow", a_shadow, 32'hA5);
    check("wr_state", 64'(dut.state_q), 64'(TRACK));
    ret2(0, 1, 32'hFFFF_FFFF, 32'h0000_00A5, 0, 0);
    step();
    check("rd_mis", a_mis, 0);
    check("rd_known", a_known, 32'hFFFF_FFFF);
    check("rd_count", a_cnt, 2);
    check("rd_oe", a_oe, 0);

    // 3: contradicting read, then a later one that must not re-capture
    ret2(0, 2, 32'hFFFF_FFFF, 32'h0000_00A4, 0, 0);
    step();
    check("m1_mis", a_mis, 1);
    check("m1_bits", a_bits, 1);
    check("m1_order", a_order, 2);
    check("m1_sticky", a_sticky, 1);
    check("m1_state", 64'(dut.state_q), 64'(ERROR));
    step();
    check("m1_pulse_end", a_mis, 0);
    ret2(0, 3, 32'hFFFF_FFFF, 32'h0000_00A5, 0, 0);
    step();
    check("m2_mis", a_mis, 1);
    check("m2_order_held", a_order, 2);
    check("m2_bits_held", a_bits, 1);
    check("m2_shadow", a_shadow, 32'hA5);

    // 4: two channels in one cycle, ch1 sees ch0's write
    do_reset();
    ret2(0, 10, 0, 0, 32'hFF, 32'h10);
    ret2(1, 11, 32'hFF, 32'h10, 0, 0);
    step();
    check("dual_mis", a_mis, 0);
    check("dual_shadow", a_shadow, 32'h10);
    check("dual_known", a_known, 32'hFF);
    check("dual_count", a_cnt, 2);
    ret2(0, 12, 0, 0, 32'hFF, 32'h10);
    ret2(1, 13, 32'hFF, 32'h11, 0, 0);
    step();
    check("dual_bad_mis", a_mis, 1);
    check("dual_bad_bits", a_bits, 1);
    check("dual_bad_order", a_order, 13);
    check("dual_bad_shadow", a_shadow, 32'h11);
    check("dual_bad_count", a_cnt, 4);

    // 5: order gap, recovery, wrap and repeat
    do_reset();
    ret2(0, 5, 0, 0, 0, 0); step();
    check("ord5_oe", a_oe, 0);
    ret2(0, 6, 0, 0, 0, 0); step();
    check("ord6_oe", a_oe, 0);
    ret2(0, 8, 0, 0, 0, 0); step();
    check("ord8_oe", a_oe, 1);
    check("ord8_err_order", a_order, 8);
    check("ord8_err_bits", a_bits, 0);
    check("ord8_mis", a_mis, 0);
    check("ord8_sticky", a_sticky, 1);
    ret2(0, 9, 0, 0, 0, 0); step();
    check("ord9_oe", a_oe, 0);
    do_reset();
    ret2(0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0); step();
    ret2(0, 0, 0, 0, 0, 0); step();
    check("wrap_oe", a_oe, 0);
    ret2(0, 0, 0, 0, 0, 0); step();
    check("repeat_oe", a_oe, 1);
    check("repeat_err_order", a_order, 0);

    // order error on ch0 and mismatch on ch1 together: ch0 wins capture
    do_reset();
    ret2(0, 20, 0, 0, 32'hFF, 32'h0); step();
    ret2(0, 22, 0, 0, 0, 0);
    ret2(1, 23, 32'hFF, 32'h1, 0, 0);
    step();
    check("both_mis", a_mis, 1);
    check("both_oe", a_oe, 1);
    check("both_err_order", a_order, 22);
    check("both_err_bits", a_bits, 0);

    // 6: volatile CSR never becomes known
    ret1(0, 0, 0, 32'hFFFF_FFFF, 32'h100); step();
    ret1(1, 32'hFFFF_FFFF, 32'h105, 0, 0); step();
    check("vol_mis", v_mis, 0);
    check("vol_known", v_known, 0);
    check("vol_shadow", v_shadow, 32'h105);
    check("vol_count", v_cnt, 2);
    ret1(2, 32'hFFFF_FFFF, 32'h200, 0, 0);
    ret2(0, 30, 0, 0, 32'hFF, 32'h55);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_vshadow", v_shadow, 0);
    check("midrst_vcount", v_cnt, 0);
    check("midrst_vstate", 64'(dut_v.state_q), 64'(IDLE));
    check("midrst_shadow", a_shadow, 0);
    check("midrst_sticky", a_sticky, 0);
    check("midrst_count", a_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
